// File: rtl/pc_reg.sv
// Program-counter register: holds the fetch address, with PC+4, misalignment and fetch-window fault flags.
// Optional hold input enabled by defining PC_STALL_EN.
module pc_reg #(
    parameter logic [31:0] RESET_ADDR = 32'h0100_0000,
    parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PC_STALL_EN
    input  logic        stall,
`endif
    input  logic [31:0] next_pc,
    output logic [31:0] current_pc,
    output logic [31:0] pc_plus4,
    output logic        pc_misaligned,
    output logic        pc_fault
);

    // Window bounds are held in 33 bits so IMEM_BASE + IMEM_BYTES cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, IMEM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, IMEM_BASE} + 33'(IMEM_BYTES);

    logic [31:0] aligned_pc;
    logic        next_misaligned;
    logic        next_fault;
    logic        load_en;

    assign aligned_pc      = {next_pc[31:2], 2'b00};
    assign next_misaligned = (next_pc[1:0] != 2'b00);
    assign next_fault      = ({1'b0, aligned_pc} < WIN_LO) || ({1'b0, aligned_pc} >= WIN_HI);

`ifdef PC_STALL_EN
    assign load_en = ~stall;
`else
    assign load_en = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is checked first so it beats stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc    <= RESET_ADDR;
            pc_misaligned <= 1'b0;
            pc_fault      <= 1'b0;
        end else if (load_en) begin
            current_pc    <= aligned_pc;
            pc_misaligned <= next_misaligned;
            pc_fault      <= next_fault;
        end
    end

    // Wraps modulo 2^32 by construction of the 32-bit sum.
    assign pc_plus4 = current_pc + 32'd4;

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed vector table, hand-written corner sequences,
// and randomized traffic compared against an arithmetic reference model.
module tb_pc_reg;

    localparam logic [31:0] RESET_ADDR = 32'h0100_0000;
    localparam logic [31:0] IMEM_BASE  = 32'h0100_0000;
    localparam int unsigned IMEM_BYTES = 4096;
`ifdef PC_STALL_EN
    localparam bit HAS_STALL = 1'b1;
`else
    localparam bit HAS_STALL = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] next_pc;
    logic [31:0] current_pc;
    logic [31:0] pc_plus4;
    logic        pc_misaligned;
    logic        pc_fault;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_mis;
    logic        m_fault;

    pc_reg #(
        .RESET_ADDR(RESET_ADDR),
        .IMEM_BASE (IMEM_BASE),
        .IMEM_BYTES(IMEM_BYTES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef PC_STALL_EN
        .stall        (stall),
`endif
        .next_pc      (next_pc),
        .current_pc   (current_pc),
        .pc_plus4     (pc_plus4),
        .pc_misaligned(pc_misaligned),
        .pc_fault     (pc_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] npc;
        logic [31:0] exp_pc;
        logic [31:0] exp_p4;
        logic        exp_mis;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    endtask

    // Model: computed from the address rules with wide integer arithmetic.
    task automatic model_update(input logic r, input logic s, input logic [31:0] n);
        longint unsigned addr;
        if (r) begin
            m_pc = RESET_ADDR; m_mis = 1'b0; m_fault = 1'b0;
        end else if (!(HAS_STALL && s)) begin
            addr    = longint'(n) - (longint'(n) % 4);
            m_pc    = addr[31:0];
            m_mis   = (n % 4) != 0;
            m_fault = (addr < longint'(IMEM_BASE)) || (addr >= longint'(IMEM_BASE) + IMEM_BYTES);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [31:0] n);
        reset = r; stall = s; next_pc = n;
        @(posedge clk);
        model_update(r, s, n);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic emis, input logic efault);
        check({tag, ".current_pc"}, current_pc, epc);
        check({tag, ".pc_plus4"}, pc_plus4, epc + 32'd4);
        check({tag, ".pc_misaligned"}, 32'(pc_misaligned), 32'(emis));
        check({tag, ".pc_fault"}, 32'(pc_fault), 32'(efault));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; next_pc = 32'h0100_0000;
        m_pc = '0; m_mis = 1'b0; m_fault = 1'b0;

        //          rst   next_pc        current_pc     pc_plus4       mis   fault
        vecs[0]  = '{1'b1, 32'h0100_0000, 32'h0100_0000, 32'h0100_0004, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hDEAD_BEEF, 32'h0100_0000, 32'h0100_0004, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h0100_0000, 32'h0100_0000, 32'h0100_0004, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0100_0004, 32'h0100_0004, 32'h0100_0008, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0100_0008, 32'h0100_0008, 32'h0100_000C, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0100_000C, 32'h0100_000C, 32'h0100_0010, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h0100_0020, 32'h0100_0000, 32'h0100_0004, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0100_0006, 32'h0100_0004, 32'h0100_0008, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0100_0008, 32'h0100_0008, 32'h0100_000C, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h00FF_FFFC, 32'h00FF_FFFC, 32'h0100_0000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0100_1000, 32'h0100_1000, 32'h0100_1004, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 32'h0100_0FFC, 32'h0100_0FFC, 32'h0100_1000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 32'h0100_0FFC, 32'h0100_0000, 32'h0100_0004, 1'b0, 1'b0};

        #1;
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, 1'b0, vecs[i].npc);
            check($sformatf("vec%0d.current_pc", i), current_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d.pc_plus4", i), pc_plus4, vecs[i].exp_p4);
            check($sformatf("vec%0d.pc_misaligned", i), 32'(pc_misaligned), 32'(vecs[i].exp_mis));
            check($sformatf("vec%0d.pc_fault", i), 32'(pc_fault), 32'(vecs[i].exp_fault));
        end

        // next_pc changing between edges must not reach any output.
        step(1'b0, 1'b0, 32'h0100_0040);
        next_pc = 32'h0100_0ABF;
        #3;
        check_all("no_comb_path", 32'h0100_0040, 1'b0, 1'b0);

        // Reset mid-stream, then the first load after release takes next_pc on the next edge.
        step(1'b1, 1'b0, 32'h0100_0ABC);
        check_all("mid_reset", 32'h0100_0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0100_0ABC);
        check_all("first_after_reset", 32'h0100_0ABC, 1'b0, 1'b0);

`ifdef PC_STALL_EN
        // Stall holds the PC and both flags.
        step(1'b0, 1'b0, 32'h0100_2002);
        check_all("pre_stall", 32'h0100_2000, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0100_0010);
        check_all("stall_edge1", 32'h0100_2000, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0100_0010);
        check_all("stall_edge2", 32'h0100_2000, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0100_0010);
        check_all("stall_with_reset", 32'h0100_0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0100_0010);
        check_all("stall_release", 32'h0100_0010, 1'b0, 1'b0);
`endif

        // Randomized traffic against the model; half the addresses land near the fetch window.
        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        s;
            logic [31:0] n;
            r = ($urandom_range(0, 15) == 0);
            s = HAS_STALL ? ($urandom_range(0, 3) == 0) : 1'b0;
            if ($urandom_range(0, 1) == 0)
                n = IMEM_BASE - 32'd64 + 32'($urandom_range(0, IMEM_BYTES + 128));
            else
                n = $urandom;
            step(r, s, n);
            check_all($sformatf("rand%0d", i), m_pc, m_mis, m_fault);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
